// File: rtl/rv32_mod_regfile_wb_arbiter.sv
// Writeback arbiter for the single regfile write port, plus the pending-write scoreboard.
// Define RV32_WB_ARB_AGING_EN to promote requesters that have waited STARVE_LIMIT cycles.
module rv32_mod_regfile_wb_arbiter #(
    parameter int unsigned N_REQ        = 3,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*5-1:0]    req_index,
    input  logic [N_REQ*32-1:0]   req_data,
    output logic [4:0]            write0_index,
    output logic [31:0]           write0_data,
    output logic                  write0_enable,
    input  logic                  reserve_valid,
    input  logic [4:0]            reserve_index,
    output logic                  reserve_ready,
    input  logic [4:0]            query0_index,
    output logic                  query0_busy,
    input  logic [4:0]            query1_index,
    output logic                  query1_busy,
    input  logic                  flush,
    output logic [31:0]           busy_vector
);

    logic [N_REQ-1:0] grant;
    logic             found;
    logic [4:0]       sel_idx;
    logic [31:0]      sel_data;

    logic             wr_en_q, wr_en_d;
    logic [4:0]       wr_idx_q;
    logic [31:0]      wr_data_q;
    logic [31:0]      busy_q, busy_d;

`ifdef RV32_WB_ARB_AGING_EN
    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

    logic [CntW-1:0]  wait_q [N_REQ];
    logic [CntW-1:0]  wait_d [N_REQ];
    logic [N_REQ-1:0] starving;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            starving[i] = (wait_q[i] == CntW'(STARVE_LIMIT));
            wait_d[i]   = wait_q[i];
            if (!req_valid[i] || grant[i]) begin
                wait_d[i] = '0;
            end else if (!starving[i]) begin
                wait_d[i] = wait_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                wait_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                wait_q[i] <= wait_d[i];
            end
        end
    end
`endif

    // Starving requesters (aging builds only) take precedence, then fixed priority.
    always_comb begin
        grant = '0;
        found = 1'b0;
`ifdef RV32_WB_ARB_AGING_EN
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_valid[i] && starving[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
`endif
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_valid[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        if (!rst_n) begin
            grant = '0;
        end
    end

    always_comb begin
        sel_idx  = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_idx  = req_index[i*5 +: 5];
                sel_data = req_data[i*32 +: 32];
            end
        end
    end

    assign wr_en_d = (|grant) && (sel_idx != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_idx_q  <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_idx_q  <= sel_idx;
            wr_data_q <= sel_data;
        end
    end

    // Readiness comes from registered state only, so a same-edge set can only hit a free entry.
    assign reserve_ready = rst_n && ((reserve_index == 5'd0) || !busy_q[reserve_index]);

    always_comb begin
        busy_d = busy_q;
        if (wr_en_q) begin
            busy_d[wr_idx_q] = 1'b0;
        end
        if (reserve_valid && reserve_ready && (reserve_index != 5'd0)) begin
            busy_d[reserve_index] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign req_ready     = grant;
    assign write0_enable = wr_en_q;
    assign write0_index  = wr_idx_q;
    assign write0_data   = wr_data_q;
    assign busy_vector   = busy_q;
    assign query0_busy   = busy_q[query0_index];
    assign query1_busy   = busy_q[query1_index];

endmodule

// File: tb/tb_rv32_mod_regfile_wb_arbiter.sv
// Self-checking bench: arbitration table, directed multi-cycle sequences, then random
// traffic against a behavioural model of grants, the write stage and the scoreboard.
module tb_rv32_mod_regfile_wb_arbiter;

    localparam int unsigned NReq  = 3;
    localparam int unsigned Limit = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NReq-1:0]     req_valid;
    logic [NReq-1:0]     req_ready;
    logic [NReq*5-1:0]   req_index;
    logic [NReq*32-1:0]  req_data;
    logic [4:0]          write0_index;
    logic [31:0]         write0_data;
    logic                write0_enable;
    logic                reserve_valid;
    logic [4:0]          reserve_index;
    logic                reserve_ready;
    logic [4:0]          query0_index;
    logic                query0_busy;
    logic [4:0]          query1_index;
    logic                query1_busy;
    logic                flush;
    logic [31:0]         busy_vector;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rv32_mod_regfile_wb_arbiter #(
        .N_REQ        (NReq),
        .STARVE_LIMIT (Limit)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_index     (req_index),
        .req_data      (req_data),
        .write0_index  (write0_index),
        .write0_data   (write0_data),
        .write0_enable (write0_enable),
        .reserve_valid (reserve_valid),
        .reserve_index (reserve_index),
        .reserve_ready (reserve_ready),
        .query0_index  (query0_index),
        .query0_busy   (query0_busy),
        .query1_index  (query1_index),
        .query1_busy   (query1_busy),
        .flush         (flush),
        .busy_vector   (busy_vector)
    );

    typedef struct {
        logic [NReq-1:0] valid;
        logic [NReq-1:0] exp_ready;
    } arb_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] idx,
                           input logic [31:0] d);
        req_valid[i]           = v;
        req_index[i*5 +: 5]    = idx;
        req_data[i*32 +: 32]   = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    // Behavioural model state
    logic [31:0]     m_busy;
    logic            m_en;
    logic [4:0]      m_idx;
    logic [31:0]     m_data;
    int              m_wait [NReq];
    logic [NReq-1:0] m_gr;

    initial begin
        arb_vec_t tbl [8];
        int       win;
        logic [NReq-1:0] exp_ready;
        logic     exp_rr;

        tbl[0] = '{valid: 3'b000, exp_ready: 3'b000};
        tbl[1] = '{valid: 3'b001, exp_ready: 3'b001};
        tbl[2] = '{valid: 3'b010, exp_ready: 3'b010};
        tbl[3] = '{valid: 3'b100, exp_ready: 3'b100};
        tbl[4] = '{valid: 3'b011, exp_ready: 3'b001};
        tbl[5] = '{valid: 3'b110, exp_ready: 3'b010};
        tbl[6] = '{valid: 3'b101, exp_ready: 3'b001};
        tbl[7] = '{valid: 3'b111, exp_ready: 3'b001};

        rst_n = 1'b0;
        req_valid = '0; req_index = '0; req_data = '0;
        reserve_valid = 1'b0; reserve_index = '0;
        query0_index = '0; query1_index = '0; flush = 1'b0;

        // Reset state, with live requests present
        req_valid = 3'b111;
        reserve_index = 5'd3;
        settle();
        chk("rst_req_ready", {29'd0, req_ready}, 32'd0);
        chk("rst_reserve_ready", {31'd0, reserve_ready}, 32'd0);
        chk("rst_we", {31'd0, write0_enable}, 32'd0);
        chk("rst_widx", {27'd0, write0_index}, 32'd0);
        chk("rst_wdata", write0_data, 32'd0);
        chk("rst_busy", busy_vector, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        req_valid = '0;
        next_cycle();

        // Arbitration table
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NReq; i++) begin
                set_req(i, tbl[k].valid[i], 5'(20 + i), 32'h100 * k + i);
            end
            settle();
            chk("arb_tbl", {29'd0, req_ready}, {29'd0, tbl[k].exp_ready});
            next_cycle();
            req_valid = '0;
            next_cycle();
        end

        // Async reset mid-stream with a registered write and busy = 0xA0
        reserve_valid = 1'b1; reserve_index = 5'd5;
        next_cycle();
        reserve_index = 5'd7;
        set_req(0, 1'b1, 5'd1, 32'h11);
        next_cycle();
        reserve_valid = 1'b0; req_valid = '0;
        settle();
        chk("t1_busy_pre", busy_vector, 32'h0000_00A0);
        chk("t1_we_pre", {31'd0, write0_enable}, 32'd1);
        rst_n = 1'b0;
        req_valid = 3'b111; reserve_valid = 1'b1; reserve_index = 5'd9;
        #1;
        chk("t1_we", {31'd0, write0_enable}, 32'd0);
        chk("t1_widx", {27'd0, write0_index}, 32'd0);
        chk("t1_busy", busy_vector, 32'd0);
        chk("t1_req_ready", {29'd0, req_ready}, 32'd0);
        chk("t1_reserve_ready", {31'd0, reserve_ready}, 32'd0);
        next_cycle();
        rst_n = 1'b1; req_valid = '0; reserve_valid = 1'b0;
        next_cycle();

        // Reserve x5, write it from req1, busy clears two cycles after the grant
        reserve_valid = 1'b1; reserve_index = 5'd5;
        settle();
        chk("t2_rr", {31'd0, reserve_ready}, 32'd1);
        next_cycle();
        reserve_valid = 1'b0; query0_index = 5'd5;
        set_req(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
        settle();
        chk("t2_busy", busy_vector, 32'h20);
        chk("t2_q0_set", {31'd0, query0_busy}, 32'd1);
        chk("t2_grant", {29'd0, req_ready}, 32'b010);
        next_cycle();
        req_valid = '0;
        settle();
        chk("t2_we", {31'd0, write0_enable}, 32'd1);
        chk("t2_widx", {27'd0, write0_index}, 32'd5);
        chk("t2_wdata", write0_data, 32'hDEAD_BEEF);
        chk("t2_q0_inflight", {31'd0, query0_busy}, 32'd1);
        next_cycle();
        settle();
        chk("t2_q0_clear", {31'd0, query0_busy}, 32'd0);
        chk("t2_busy_clear", busy_vector, 32'd0);
        next_cycle();

        // req0 and req2 held valid: starvation behaviour
        set_req(0, 1'b1, 5'd2, 32'hA0A0);
        set_req(2, 1'b1, 5'd3, 32'hC2C2);
        for (int k = 0; k < 8; k++) begin
            settle();
`ifdef RV32_WB_ARB_AGING_EN
            chk("t3_aging", {29'd0, req_ready}, (k == 4) ? 32'b100 : 32'b001);
`else
            chk("t3_fixed", {29'd0, req_ready}, 32'b001);
`endif
            next_cycle();
        end
        req_valid = '0;
        next_cycle();
        next_cycle();

        // x0: reservation accepted without effect, write granted but not enabled
        reserve_valid = 1'b1; reserve_index = 5'd2;
        next_cycle();
        reserve_index = 5'd0;
        set_req(0, 1'b1, 5'd0, 32'h1234);
        settle();
        chk("t4_rr_x0", {31'd0, reserve_ready}, 32'd1);
        chk("t4_grant", {29'd0, req_ready}, 32'b001);
        next_cycle();
        reserve_valid = 1'b0; req_valid = '0;
        settle();
        chk("t4_busy", busy_vector, 32'h4);
        chk("t4_we", {31'd0, write0_enable}, 32'd0);
        next_cycle();

        // Double reserve of x7 blocks until the write commits; then flush beats a reserve
        reserve_valid = 1'b1; reserve_index = 5'd7;
        settle();
        chk("t5_rr_first", {31'd0, reserve_ready}, 32'd1);
        next_cycle();
        set_req(0, 1'b1, 5'd7, 32'h77);
        settle();
        chk("t5_rr_busy", {31'd0, reserve_ready}, 32'd0);
        chk("t5_grant", {29'd0, req_ready}, 32'b001);
        next_cycle();
        req_valid = '0;
        settle();
        chk("t5_we", {31'd0, write0_enable}, 32'd1);
        chk("t5_widx", {27'd0, write0_index}, 32'd7);
        chk("t5_rr_inflight", {31'd0, reserve_ready}, 32'd0);
        next_cycle();
        settle();
        chk("t5_rr_free", {31'd0, reserve_ready}, 32'd1);
        next_cycle();
        reserve_index = 5'd3;
        next_cycle();
        reserve_index = 5'd9;
        next_cycle();
        reserve_index = 5'd4; flush = 1'b1;
        settle();
        chk("t5_busy_pre", busy_vector, 32'h0000_028C);
        next_cycle();
        flush = 1'b0; reserve_valid = 1'b0;
        settle();
        chk("t5_flush", busy_vector, 32'd0);
        next_cycle();

        // Three back-to-back writes in priority order
        set_req(0, 1'b1, 5'd10, 32'hAAAA_0000);
        set_req(1, 1'b1, 5'd11, 32'hBBBB_1111);
        set_req(2, 1'b1, 5'd12, 32'hCCCC_2222);
        settle();
        chk("t6_g0", {29'd0, req_ready}, 32'b001);
        chk("t6_we0", {31'd0, write0_enable}, 32'd0);
        next_cycle();
        req_valid[0] = 1'b0;
        settle();
        chk("t6_g1", {29'd0, req_ready}, 32'b010);
        chk("t6_w1", {26'd0, write0_enable, write0_index}, {26'd0, 1'b1, 5'd10});
        chk("t6_d1", write0_data, 32'hAAAA_0000);
        next_cycle();
        req_valid[1] = 1'b0;
        settle();
        chk("t6_g2", {29'd0, req_ready}, 32'b100);
        chk("t6_w2", {26'd0, write0_enable, write0_index}, {26'd0, 1'b1, 5'd11});
        chk("t6_d2", write0_data, 32'hBBBB_1111);
        next_cycle();
        req_valid[2] = 1'b0;
        settle();
        chk("t6_w3", {26'd0, write0_enable, write0_index}, {26'd0, 1'b1, 5'd12});
        chk("t6_d3", write0_data, 32'hCCCC_2222);
        next_cycle();
        settle();
        chk("t6_idle", {31'd0, write0_enable}, 32'd0);
        next_cycle();

        // Random traffic against the model, from a fresh reset
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        req_valid = '0; reserve_valid = 1'b0; flush = 1'b0;
        m_busy = '0; m_en = 1'b0; m_idx = '0; m_data = '0; m_gr = '0;
        for (int i = 0; i < NReq; i++) m_wait[i] = 0;

        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NReq; i++) begin
                if (!(req_valid[i] && !m_gr[i] && $urandom_range(7) != 0)) begin
                    set_req(i, 1'($urandom_range(1)), 5'($urandom_range(31)), $urandom());
                end
            end
            reserve_valid = 1'($urandom_range(1));
            reserve_index = 5'($urandom_range(31));
            query0_index  = 5'($urandom_range(31));
            query1_index  = 5'($urandom_range(31));
            flush         = ($urandom_range(15) == 0);

            win = -1;
`ifdef RV32_WB_ARB_AGING_EN
            for (int i = 0; i < NReq; i++) begin
                if (win < 0 && req_valid[i] && m_wait[i] >= Limit) win = i;
            end
`endif
            for (int i = 0; i < NReq; i++) begin
                if (win < 0 && req_valid[i]) win = i;
            end
            exp_ready = (win >= 0) ? NReq'(1 << win) : '0;
            exp_rr = (reserve_index == 0) || !m_busy[reserve_index];

            settle();
            chk("rnd_ready", {29'd0, req_ready}, {29'd0, exp_ready});
            chk("rnd_we", {31'd0, write0_enable}, {31'd0, m_en});
            if (m_en) begin
                chk("rnd_widx", {27'd0, write0_index}, {27'd0, m_idx});
                chk("rnd_wdata", write0_data, m_data);
            end
            chk("rnd_busy", busy_vector, m_busy);
            chk("rnd_rr", {31'd0, reserve_ready}, {31'd0, exp_rr});
            chk("rnd_q0", {31'd0, query0_busy}, {31'd0, m_busy[query0_index]});
            chk("rnd_q1", {31'd0, query1_busy}, {31'd0, m_busy[query1_index]});

            @(posedge clk);
`ifdef RV32_WB_ARB_AGING_EN
            for (int i = 0; i < NReq; i++) begin
                if (req_valid[i] && win != i) m_wait[i] = (m_wait[i] < Limit) ? m_wait[i] + 1 : Limit;
                else m_wait[i] = 0;
            end
`endif
            if (m_en) m_busy[m_idx] = 1'b0;
            if (reserve_valid && exp_rr && reserve_index != 0) m_busy[reserve_index] = 1'b1;
            if (flush) m_busy = '0;
            m_en = 1'b0;
            if (win >= 0) begin
                m_idx  = req_index[win*5 +: 5];
                m_data = req_data[win*32 +: 32];
                m_en   = (m_idx != 5'd0);
            end
            m_gr = exp_ready;
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
